ctrl_pipeline: RTL and testbench

//  Parametrised control-path pipeline for the 5-stage MIPS core. Carries an opaque decoded

---
 rtl/ctrl_pipeline.sv | 139 +++++++++++++
 tb/tb_ctrl_pipeline.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline
//
// Control-path pipeline for the 5-stage MIPS core. It carries the decoded
// control bundle from D through E, M and W, with a valid bit in each stage.
// It generates the stall and flush controls for load-use hazards and for
// multi-cycle execute ops (mult/div), and it resolves beq/bne in D.
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high
//   ctrlD      in   CTRL_W  decoded control bundle of the instruction in D
//   validD     in   1       D holds a real instruction
//   rsD, rtD   in   REG_W   source registers of the instruction in D
//   writeregE  in   REG_W   destination register of the instruction in E
//   brtypeD    in   2       00 none, 01 beq, 10 bne, 11 reserved (none)
//   equalD     in   1       D-stage register comparator result
//   pcsrcD     out  1       take branch
//   stallF     out  1       hold PC
//   stallD     out  1       hold IF/ID register
//   flushE     out  1       a bubble enters E this cycle
//   mc_busyE   out  1       multi-cycle op in E still executing
//   ctrlE/M/W  out  CTRL_W  control bundle of each stage
//   validE/M/W out  1       stage holds a real instruction
// ---------------------------------------------------------------------------
module ctrl_pipeline #(
    parameter int CTRL_W   = 10,
    parameter int REG_W    = 5,
    parameter int LOAD_BIT = 0,
    parameter int MC_BIT   = 1,
    parameter int MC_LAT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic              validD,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rtD,
    input  logic [REG_W-1:0]  writeregE,
    input  logic [1:0]        brtypeD,
    input  logic              equalD,
    output logic              pcsrcD,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              mc_busyE,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [CTRL_W-1:0] ctrlM,
    output logic [CTRL_W-1:0] ctrlW,
    output logic              validE,
    output logic              validM,
    output logic              validW
);

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_RSVD = 2'b11
    } br_type_e;

    // Last count value of a multi-cycle op; E releases when cnt reaches it.
    localparam logic [7:0] MC_LAST = 8'(MC_LAT - 1);

    logic [7:0] cnt;
    logic       lwstall;
    logic       mcstall;
    logic       take;

    // Hazard and branch decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        lwstall = 1'b0;
        mcstall = 1'b0;
        take    = 1'b0;

        // Register 0 is hard-wired zero, so a load into it is never a hazard.
        lwstall = validD & validE & ctrlE[LOAD_BIT] & (writeregE != '0)
                & ((writeregE == rsD) | (writeregE == rtD));
        mcstall = validE & ctrlE[MC_BIT] & (cnt != MC_LAST);

        unique case (br_type_e'(brtypeD))
            BR_BEQ:  take = equalD;
            BR_BNE:  take = ~equalD;
            default: take = 1'b0;
        endcase
    end

    assign stallF   = lwstall | mcstall;
    assign stallD   = lwstall | mcstall;
    // While a multi-cycle op holds E it must not be overwritten by a bubble.
    assign flushE   = lwstall & ~mcstall;
    assign mc_busyE = mcstall;
    assign pcsrcD   = validD & ~stallD & take;

    // Stage registers and multi-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 8'd0;
            ctrlE  <= '0;
            ctrlM  <= '0;
            ctrlW  <= '0;
            validE <= 1'b0;
            validM <= 1'b0;
            validW <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the previous stage's value from before the edge.
            // The counter restarts on the cycle E advances, so a following
            // multi-cycle op starts counting on its first cycle in E.
            cnt <= mcstall ? cnt + 8'd1 : 8'd0;

            if (mcstall) begin
                ctrlE  <= ctrlE;
                validE <= validE;
            end else if (flushE) begin
                ctrlE  <= '0;
                validE <= 1'b0;
            end else begin
                ctrlE  <= ctrlD;
                validE <= validD;
            end

            // E is busy, so M receives a bubble each stalled cycle.
            if (mcstall) begin
                ctrlM  <= '0;
                validM <= 1'b0;
            end else begin
                ctrlM  <= ctrlE;
                validM <= validE;
            end

            ctrlW  <= ctrlM;
            validW <= validM;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipeline
//
// Directed bench for ctrl_pipeline with the default parameters (CTRL_W=10,
// LOAD_BIT=0, MC_BIT=1, MC_LAT=4). Inputs change 1 ns after a rising edge.
// Combinational outputs are checked 1 ns after that. Stage registers are
// checked 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_ctrl_pipeline;

    localparam int CTRL_W = 10;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CTRL_W-1:0] ctrlD = '0;
    logic              validD = 1'b0;
    logic [REG_W-1:0]  rsD = '0;
    logic [REG_W-1:0]  rtD = '0;
    logic [REG_W-1:0]  writeregE = '0;
    logic [1:0]        brtypeD = 2'b00;
    logic              equalD = 1'b0;

    logic              pcsrcD, stallF, stallD, flushE, mc_busyE;
    logic [CTRL_W-1:0] ctrlE, ctrlM, ctrlW;
    logic              validE, validM, validW;

    int checks = 0;
    int errors = 0;

    ctrl_pipeline dut (
        .clk       (clk),
        .reset     (reset),
        .ctrlD     (ctrlD),
        .validD    (validD),
        .rsD       (rsD),
        .rtD       (rtD),
        .writeregE (writeregE),
        .brtypeD   (brtypeD),
        .equalD    (equalD),
        .pcsrcD    (pcsrcD),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushE    (flushE),
        .mc_busyE  (mc_busyE),
        .ctrlE     (ctrlE),
        .ctrlM     (ctrlM),
        .ctrlW     (ctrlW),
        .validE    (validE),
        .validM    (validM),
        .validW    (validW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CTRL_W-1:0] c, input logic v,
                         input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic [REG_W-1:0] wre, input logic [1:0] br,
                         input logic eq);
        ctrlD     = c;
        validD    = v;
        rsD       = rs;
        rtD       = rt;
        writeregE = wre;
        brtypeD   = br;
        equalD    = eq;
        #1;
    endtask

    task automatic check_regs(input string tag,
                              input logic [CTRL_W-1:0] ce, input logic ve,
                              input logic [CTRL_W-1:0] cm, input logic vm,
                              input logic [CTRL_W-1:0] cw, input logic vw);
        check({tag, ".ctrlE"},  32'(ctrlE),  32'(ce));
        check({tag, ".validE"}, 32'(validE), 32'(ve));
        check({tag, ".ctrlM"},  32'(ctrlM),  32'(cm));
        check({tag, ".validM"}, 32'(validM), 32'(vm));
        check({tag, ".ctrlW"},  32'(ctrlW),  32'(cw));
        check({tag, ".validW"}, 32'(validW), 32'(vw));
    endtask

    task automatic check_comb(input string tag, input logic st, input logic fl,
                              input logic busy, input logic pc);
        check({tag, ".stallF"},   32'(stallF),   32'(st));
        check({tag, ".stallD"},   32'(stallD),   32'(st));
        check({tag, ".flushE"},   32'(flushE),   32'(fl));
        check({tag, ".mc_busyE"}, 32'(mc_busyE), 32'(busy));
        check({tag, ".pcsrcD"},   32'(pcsrcD),   32'(pc));
    endtask

    // Independent instructions: neither the load nor the mc bit set.
    logic [CTRL_W-1:0] flow_vec [6] = '{10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080};

    function automatic logic [CTRL_W-1:0] flow_ctrl(input int k);
        return (k >= 0 && k < 6) ? flow_vec[k] : '0;
    endfunction

    function automatic logic flow_valid(input int k);
        return (k >= 0 && k < 6);
    endfunction

    initial begin
        // ---- reset state ----
        tick();
        tick();
        check_regs("reset", '0, 0, '0, 0, '0, 0);
        check_comb("reset", 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // ---- flow: E/M/W after 1/2/3 cycles ----
        for (int i = 0; i < 9; i++) begin
            drive(flow_ctrl(i), flow_valid(i), 0, 0, 0, 2'b00, 0);
            check_comb("flow", 0, 0, 0, 0);
            tick();
            check_regs($sformatf("flow%0d", i),
                       flow_ctrl(i), flow_valid(i),
                       flow_ctrl(i - 1), flow_valid(i - 1),
                       flow_ctrl(i - 2), flow_valid(i - 2));
        end

        // ---- load-use through rs ----
        drive(10'h101, 1, 1, 2, 0, 2'b00, 0);
        tick();
        check_regs("lw_in_E", 10'h101, 1, '0, 0, '0, 0);
        // A taken bne is suppressed while D is stalled.
        drive(10'h204, 1, 8, 3, 8, 2'b10, 0);
        check_comb("lwstall", 1, 1, 0, 0);
        tick();
        check_regs("lw_bubble", '0, 0, 10'h101, 1, '0, 0);
        drive(10'h204, 1, 8, 3, 0, 2'b00, 0);
        check_comb("lw_after", 0, 0, 0, 0);
        tick();
        check_regs("lw_dep_in_E", 10'h204, 1, '0, 0, 10'h101, 1);

        // ---- load to r0: no hazard; rt match does stall ----
        drive(10'h001, 1, 0, 0, 0, 2'b00, 0);
        tick();
        check_regs("lw_r0_in_E", 10'h001, 1, 10'h204, 1, '0, 0);
        drive(10'h008, 1, 0, 0, 0, 2'b00, 0);
        check_comb("lw_r0", 0, 0, 0, 0);
        drive(10'h008, 1, 0, 5, 5, 2'b00, 0);
        check_comb("lw_rt", 1, 1, 0, 0);
        drive(10'h008, 1, 0, 0, 0, 2'b00, 0);
        tick();
        check_regs("lw_r0_next", 10'h008, 1, 10'h001, 1, 10'h204, 1);

        // ---- branches, no stall (E holds a plain instruction) ----
        drive(10'h010, 1, 0, 0, 0, 2'b10, 0);
        check("br_bne_ne", 32'(pcsrcD), 32'd1);
        drive(10'h010, 1, 0, 0, 0, 2'b10, 1);
        check("br_bne_eq", 32'(pcsrcD), 32'd0);
        drive(10'h010, 1, 0, 0, 0, 2'b01, 1);
        check("br_beq_eq", 32'(pcsrcD), 32'd1);
        drive(10'h010, 1, 0, 0, 0, 2'b01, 0);
        check("br_beq_ne", 32'(pcsrcD), 32'd0);
        drive(10'h010, 1, 0, 0, 0, 2'b11, 0);
        check("br_rsvd0", 32'(pcsrcD), 32'd0);
        drive(10'h010, 1, 0, 0, 0, 2'b11, 1);
        check("br_rsvd1", 32'(pcsrcD), 32'd0);
        drive(10'h010, 0, 0, 0, 0, 2'b01, 1);
        check("br_invalid", 32'(pcsrcD), 32'd0);

        // ---- multi-cycle op, MC_LAT=4 ----
        drive(10'h042, 1, 0, 0, 0, 2'b00, 0);
        check_comb("mc_pre", 0, 0, 0, 0);
        tick();
        check_regs("mc_in_E", 10'h042, 1, 10'h008, 1, 10'h001, 1);
        drive(10'h010, 1, 0, 0, 0, 2'b00, 0);
        for (int k = 0; k < 3; k++) begin
            check_comb($sformatf("mc_busy%0d", k), 1, 0, 1, 0);
            tick();
            check_regs($sformatf("mc_hold%0d", k), 10'h042, 1, '0, 0,
                       (k == 0) ? 10'h008 : 10'h000, (k == 0));
        end
        check_comb("mc_done", 0, 0, 0, 0);
        tick();
        check_regs("mc_to_M", 10'h010, 1, 10'h042, 1, '0, 0);

        // ---- load+mc in E with a dependent D: hold, no flush ----
        drive(10'h003, 1, 0, 0, 0, 2'b00, 0);
        tick();
        check_regs("lwmc_in_E", 10'h003, 1, 10'h010, 1, 10'h042, 1);
        drive(10'h020, 1, 9, 0, 9, 2'b00, 0);
        check_comb("lwmc", 1, 0, 1, 0);
        tick();
        check_regs("lwmc_hold", 10'h003, 1, '0, 0, 10'h010, 1);

        // ---- asynchronous reset mid-cycle with the mc op in flight ----
        #2;
        reset = 1'b1;
        #1;
        check_regs("async_rst", '0, 0, '0, 0, '0, 0);
        check_comb("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Refill: a fresh mc op must be busy for exactly three cycles.
        drive(10'h042, 1, 0, 0, 0, 2'b00, 0);
        tick();
        check_regs("refill", 10'h042, 1, '0, 0, '0, 0);
        drive('0, 0, 0, 0, 0, 2'b00, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("refill_busy%0d", k), 32'(mc_busyE), 32'd1);
            tick();
        end
        check("refill_done", 32'(mc_busyE), 32'd0);
        tick();
        check_regs("refill_M", '0, 0, 10'h042, 1, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
